cache_axi_read_bridge: RTL and testbench
========================================

Name: cache_axi_read_bridge

Overview:
- Read-only bridge from a cache/MMU access port (cache_access_interface semantics) to an AXI4 read channel pair (axi_ar / axi_r).
- Each accepted request becomes one AXI read burst: a single beat for a word access, or a full line fill for a line access.
- Collected data is returned on a one-cycle response pulse.
- Used by the i/d MMU page-table walkers and by cache refill paths.
- Exactly one outstanding transaction at a time.

Parameters:
- XLEN, 64, AXI data width and beat width in bits.
- PADDR, 56, physical address width.
- LINE_BEATS, 8, beats per line fill; power of two, range 2..16.
- AXI_ID, 0, constant value driven on arid. Width 4.

Ports:
- clk_i  in  1  clock; all logic is posedge.
- arst_i  in  1  reset. One clock; reset is synchronous and active-high.
- req_valid  in  1  access request valid.
- req_ready  out  1  bridge can accept a request.
- req_addr  in  PADDR  byte address.
- req_size  in  2  log2 of bytes (0..3), single-beat accesses only.
- req_line  in  1  1 = line fill, 0 = single beat.
- rsp_valid  out  1  response pulse.
- rsp_data  out  LINE_BEATS*XLEN  returned data; beat k occupies bits [k*XLEN +: XLEN].
- rsp_error  out  1  any beat returned SLVERR or DECERR.
- arvalid  out  1  AXI read address valid.
- arready  in  1  AXI read address ready.
- araddr  out  PADDR  AXI read address.
- arid  out  4  AXI read ID.
- arlen  out  8  AXI burst length minus one.
- arsize  out  3  AXI beat size.
- arburst  out  2  AXI burst type.
- rvalid  in  1  AXI read data valid.
- rready  out  1  AXI read data ready.
- rdata  in  XLEN  AXI read data.
- rresp  in  2  AXI read response.
- rlast  in  1  last beat of the burst.

Behaviour:
- FSM states: IDLE, ADDR, DATA, RESP.
- Reset values: state IDLE; all outputs 0 except req_ready=1; beat counter 0; error flag 0; data buffer 0.

IDLE:
- req_ready=1.
- On req_valid at a clock edge, latch the request and go to ADDR.
- Line fill: araddr = req_addr with the low log2(LINE_BEATS*XLEN/8) bits cleared; arlen=LINE_BEATS-1; arsize=3; arburst=INCR (2'b01).
- Single beat: araddr = req_addr with the low req_size bits cleared; arlen=0; arsize=req_size; arburst=INCR.
- Clear the data buffer, beat counter and error flag.

ADDR:
- arvalid=1; AR fields are held stable until the handshake.
- On arvalid&arready, go to DATA.
- Minimum latency: request accepted at edge T, arvalid high in cycle T+1.

DATA:
- rready=1.
- Each rvalid beat is stored at buffer index = beat counter, then the counter increments.
- Beats arriving after the counter reaches arlen+1 are accepted but discarded.
- Error flag |= rresp[1].
- rid is not checked.
- On the beat with rlast=1, go to RESP.

RESP:
- rsp_valid=1 for exactly one cycle; rsp_data and rsp_error are valid in that cycle. No back-pressure.
- Next state IDLE, so a new request can be accepted the cycle after rsp_valid.
- rsp_data and rsp_error hold their values until the next request is accepted.

Boundary conditions:
- Single-beat access: rdata is placed unshifted in beat 0; all other beats are 0.
- req_valid while not IDLE is ignored, since req_ready=0.
- Reset mid-transaction: return to IDLE immediately, drop arvalid/rready, and produce no response. Only a system-wide reset may abort a burst.
- rlast on the first beat of a line fill ends the transaction; unfilled beats remain 0.
- Back-to-back: minimum per-request occupancy is 4 cycles (IDLE→ADDR→DATA→RESP) for a single beat with arready and rvalid both immediately high.

Test Plan:
- Reset: arst_i high for 2 cycles → req_ready=1, arvalid=0, rready=0, rsp_valid=0.
- Single read, req_addr=0x8000_1006, size=1, arready=1, rvalid/rlast next cycle with rdata=0x1122334455667788, rresp=0 → araddr=0x80001006, arlen=0, arsize=1, rsp_valid one cycle, beat0=0x1122334455667788, other beats 0, rsp_error=0.
- Line fill, req_addr=0x8000_0048, arready delayed 3 cycles → araddr=0x80000040 (held stable), arlen=7, arsize=3; 8 beats 0..7 with gaps → rsp_data beat k = k; rsp_valid pulses once after the rlast beat.
- Error: line fill with beat 3 rresp=2'b10 → rsp_error=1; all 8 beats are still stored.
- Reset mid-burst: assert arst_i after 2 of 8 beats → no rsp_valid; next request proceeds normally.
- Request while busy: req_valid held during DATA → no second AR until after RESP; the held request is accepted the cycle after rsp_valid.

Source files
------------

// File: rtl/cache_axi_read_bridge.sv
// cache_axi_read_bridge: read-only bridge from a cache/MMU access port to an
// AXI4 AR/R channel pair. A word access becomes a single-beat burst and a
// line access becomes a full line fill. The collected data comes back on a
// one-cycle response pulse. Only one transaction is outstanding at a time.
module cache_axi_read_bridge #(
   parameter int         XLEN       = 64,
   parameter int         PADDR      = 56,
   parameter int         LINE_BEATS = 8,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic                       clk_i,
   input  logic                       arst_i,
   input  logic                       req_valid,
   output logic                       req_ready,
   input  logic [PADDR-1:0]           req_addr,
   input  logic [1:0]                 req_size,
   input  logic                       req_line,
   output logic                       rsp_valid,
   output logic [LINE_BEATS*XLEN-1:0] rsp_data,
   output logic                       rsp_error,
   output logic                       arvalid,
   input  logic                       arready,
   output logic [PADDR-1:0]           araddr,
   output logic [3:0]                 arid,
   output logic [7:0]                 arlen,
   output logic [2:0]                 arsize,
   output logic [1:0]                 arburst,
   input  logic                       rvalid,
   output logic                       rready,
   input  logic [XLEN-1:0]            rdata,
   input  logic [1:0]                 rresp,
   input  logic                       rlast
);

   localparam int IDX_W    = $clog2(LINE_BEATS);
   localparam int CNT_W    = IDX_W + 1;
   localparam int LINE_OFF = $clog2(LINE_BEATS * XLEN / 8);

   typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

   state_t            state, state_nxt;
   logic [XLEN-1:0]   beat_buf [LINE_BEATS];
   logic [CNT_W-1:0]  beat_cnt;
   logic              err_flag;
   logic              accept;
   logic              r_hs;
   logic [PADDR-1:0]  line_mask;
   logic [PADDR-1:0]  size_mask;

   assign accept    = req_valid && req_ready;
   assign r_hs      = rvalid && rready;
   assign line_mask = ~((PADDR'(1) << LINE_OFF) - PADDR'(1));
   assign size_mask = ~((PADDR'(1) << req_size) - PADDR'(1));
   assign arid      = AXI_ID;
   assign rsp_error = err_flag;

   // State register.
   always_ff @(posedge clk_i) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      if (arst_i) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode and handshake outputs, all derived from the state.
   always_comb begin
      // NOTE: every output gets a default first so no path infers a latch.
      state_nxt = state;
      req_ready = 1'b0;
      arvalid   = 1'b0;
      rready    = 1'b0;
      rsp_valid = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) state_nxt = ADDR;
         end
         ADDR: begin
            arvalid = 1'b1;
            if (arready) state_nxt = DATA;
         end
         DATA: begin
            rready = 1'b1;
            if (rvalid && rlast) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request latch, beat collection and error accumulation.
   always_ff @(posedge clk_i) begin
      if (arst_i) begin
         araddr   <= '0;
         arlen    <= '0;
         arsize   <= '0;
         arburst  <= '0;
         beat_cnt <= '0;
         err_flag <= 1'b0;
         // NOTE: the buffer is reset because it drives rsp_data directly and
         // must read as zero after reset.
         for (int i = 0; i < LINE_BEATS; i++) beat_buf[i] <= '0;
      end else begin
         if (accept) begin
            arburst  <= 2'b01;
            beat_cnt <= '0;
            err_flag <= 1'b0;
            for (int i = 0; i < LINE_BEATS; i++) beat_buf[i] <= '0;
            if (req_line) begin
               araddr <= req_addr & line_mask;
               arlen  <= 8'(LINE_BEATS - 1);
               arsize <= 3'd3;
            end else begin
               araddr <= req_addr & size_mask;
               arlen  <= 8'd0;
               arsize <= {1'b0, req_size};
            end
         end
         if (r_hs) begin
            err_flag <= err_flag | rresp[1];
            // Beats beyond the requested burst length are accepted but dropped.
            if (9'(beat_cnt) <= 9'(arlen)) begin
               beat_buf[beat_cnt[IDX_W-1:0]] <= rdata;
               beat_cnt                      <= beat_cnt + CNT_W'(1);
            end
         end
      end
   end

   // Flatten the beat buffer onto the response bus, beat k at [k*XLEN +: XLEN].
   for (genvar g = 0; g < LINE_BEATS; g++) begin : g_rsp
      assign rsp_data[g*XLEN +: XLEN] = beat_buf[g];
   end

endmodule

// File: tb/tb_cache_axi_read_bridge.sv
// Self-checking bench for cache_axi_read_bridge: directed and randomized
// transactions checked against a behavioural model of the burst rules.
module tb_cache_axi_read_bridge;

   localparam int XLEN  = 64;
   localparam int PADDR = 56;
   localparam int LB    = 8;
   localparam int DW    = LB * XLEN;

   logic              clk_i = 1'b0;
   logic              arst_i;
   logic              req_valid;
   logic              req_ready;
   logic [PADDR-1:0]  req_addr;
   logic [1:0]        req_size;
   logic              req_line;
   logic              rsp_valid;
   logic [DW-1:0]     rsp_data;
   logic              rsp_error;
   logic              arvalid;
   logic              arready;
   logic [PADDR-1:0]  araddr;
   logic [3:0]        arid;
   logic [7:0]        arlen;
   logic [2:0]        arsize;
   logic [1:0]        arburst;
   logic              rvalid;
   logic              rready;
   logic [XLEN-1:0]   rdata;
   logic [1:0]        rresp;
   logic              rlast;

   always #5 clk_i = ~clk_i;

   cache_axi_read_bridge #(
      .XLEN(XLEN), .PADDR(PADDR), .LINE_BEATS(LB), .AXI_ID(4'd0)
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_size(req_size), .req_line(req_line),
      .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
      .arvalid(arvalid), .arready(arready), .araddr(araddr), .arid(arid),
      .arlen(arlen), .arsize(arsize), .arburst(arburst),
      .rvalid(rvalid), .rready(rready), .rdata(rdata), .rresp(rresp),
      .rlast(rlast)
   );

   int checks = 0;
   int errors = 0;

   // Model of the response the bridge must produce for the current request.
   logic [XLEN-1:0] exp_beat [LB];
   logic            exp_err;

   task automatic check(input string tag, input logic [DW-1:0] obs,
                        input logic [DW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] exp_data();
      logic [DW-1:0] v;
      v = '0;
      for (int i = 0; i < LB; i++) v[i*XLEN +: XLEN] = exp_beat[i];
      return v;
   endfunction

   // One complete transaction. data_mode: 0 random, 1 beat index, 2 fixed.
   // err_beat < 0 means no forced SLVERR. last_beat is the index carrying rlast.
   task automatic run_txn(input logic [PADDR-1:0] addr, input logic [1:0] size,
                          input logic line, input int ar_delay, input int max_gap,
                          input int err_beat, input int last_beat,
                          input int data_mode, input logic [XLEN-1:0] fixed,
                          input bit hold);
      longint unsigned  bytes;
      logic [PADDR-1:0] exp_addr;
      logic [XLEN-1:0]  d;
      logic [1:0]       resp;
      int               limit;
      bytes    = line ? longint'(LB * XLEN / 8) : (longint'(1) << size);
      exp_addr = PADDR'(longint'(addr) - (longint'(addr) % bytes));
      limit    = line ? LB : 1;
      for (int i = 0; i < LB; i++) exp_beat[i] = '0;
      exp_err = 1'b0;

      check("req_ready_idle", DW'(req_ready), DW'(1));
      req_valid = 1'b1; req_addr = addr; req_size = size; req_line = line;
      @(negedge clk_i);
      if (!hold) req_valid = 1'b0;
      check("arvalid_addr", DW'(arvalid), DW'(1));
      check("req_ready_busy", DW'(req_ready), DW'(0));
      check("araddr", DW'(araddr), DW'(exp_addr));
      check("arlen", DW'(arlen), DW'(line ? LB - 1 : 0));
      check("arsize", DW'(arsize), DW'(line ? 3 : int'(size)));
      check("arburst", DW'(arburst), DW'(1));
      check("arid", DW'(arid), DW'(0));
      for (int i = 0; i < ar_delay; i++) begin
         arready = 1'b0;
         @(negedge clk_i);
         check("araddr_hold", DW'(araddr), DW'(exp_addr));
         check("arvalid_hold", DW'(arvalid), DW'(1));
      end
      arready = 1'b1;
      @(negedge clk_i);
      arready = 1'b0;
      check("rready_data", DW'(rready), DW'(1));
      check("arvalid_drop", DW'(arvalid), DW'(0));

      for (int k = 0; k <= last_beat; k++) begin
         repeat (max_gap > 0 ? $urandom_range(max_gap, 0) : 0) @(negedge clk_i);
         if (k == last_beat) check("no_early_rsp", DW'(rsp_valid), DW'(0));
         case (data_mode)
            1:       d = XLEN'(k);
            2:       d = fixed;
            default: d = {$urandom(), $urandom()};
         endcase
         resp   = (k == err_beat) ? 2'b10 : 2'($urandom_range(1, 0));
         rvalid = 1'b1; rdata = d; rresp = resp; rlast = (k == last_beat);
         if (k < limit) exp_beat[k] = d;
         exp_err = exp_err | resp[1];
         @(negedge clk_i);
         rvalid = 1'b0; rlast = 1'b0; rresp = 2'b00;
      end

      check("rsp_valid", DW'(rsp_valid), DW'(1));
      check("rsp_data", rsp_data, exp_data());
      check("rsp_error", DW'(rsp_error), DW'(exp_err));
      check("req_ready_resp", DW'(req_ready), DW'(0));
      @(negedge clk_i);
      check("rsp_pulse_end", DW'(rsp_valid), DW'(0));
      check("req_ready_after", DW'(req_ready), DW'(1));
      check("rsp_data_hold", rsp_data, exp_data());
      check("rsp_error_hold", DW'(rsp_error), DW'(exp_err));
   endtask

   initial begin
      arst_i = 1'b1; req_valid = 1'b0; req_addr = '0; req_size = '0;
      req_line = 1'b0; arready = 1'b0; rvalid = 1'b0; rdata = '0;
      rresp = '0; rlast = 1'b0;

      // Reset held for two cycles.
      repeat (2) @(negedge clk_i);
      check("rst_req_ready", DW'(req_ready), DW'(1));
      check("rst_arvalid", DW'(arvalid), DW'(0));
      check("rst_rready", DW'(rready), DW'(0));
      check("rst_rsp_valid", DW'(rsp_valid), DW'(0));
      check("rst_rsp_data", rsp_data, '0);
      arst_i = 1'b0;
      @(negedge clk_i);

      // Single halfword read, immediate handshakes.
      run_txn(56'h8000_1006, 2'd1, 1'b0, 0, 0, -1, 0, 2, 64'h1122334455667788, 1'b0);

      // Line fill with arready delayed 3 cycles and gaps between beats.
      run_txn(56'h8000_0048, 2'd0, 1'b1, 3, 2, -1, LB - 1, 1, '0, 1'b0);

      // Line fill with SLVERR on beat 3.
      run_txn(56'h8000_0100, 2'd0, 1'b1, 0, 1, 3, LB - 1, 0, '0, 1'b0);

      // Reset in the middle of a line fill, after 2 of 8 beats.
      req_valid = 1'b1; req_addr = 56'h8000_0200; req_line = 1'b1; req_size = 2'd0;
      @(negedge clk_i);
      req_valid = 1'b0; arready = 1'b1;
      @(negedge clk_i);
      arready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         rvalid = 1'b1; rdata = {$urandom(), $urandom()}; rlast = 1'b0;
         @(negedge clk_i);
      end
      arst_i = 1'b1; rlast = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk_i);
         check("mid_rst_rsp_valid", DW'(rsp_valid), DW'(0));
         check("mid_rst_rready", DW'(rready), DW'(0));
         check("mid_rst_arvalid", DW'(arvalid), DW'(0));
         check("mid_rst_req_ready", DW'(req_ready), DW'(1));
      end
      arst_i = 1'b0; rvalid = 1'b0; rlast = 1'b0;
      @(negedge clk_i);
      check("post_rst_rsp_valid", DW'(rsp_valid), DW'(0));
      check("post_rst_rsp_data", rsp_data, '0);
      run_txn(56'h8000_0280, 2'd3, 1'b0, 1, 0, -1, 0, 0, '0, 1'b0);

      // Request held valid throughout; the same request is accepted right
      // after the response pulse, and no second AR appears before that.
      run_txn(56'h0000_1234_5678, 2'd2, 1'b0, 0, 1, -1, 0, 0, '0, 1'b1);
      run_txn(56'h0000_1234_5678, 2'd2, 1'b0, 0, 0, -1, 0, 0, '0, 1'b0);

      // Early rlast on the first beat of a line fill.
      run_txn(56'h0040_0000_0078, 2'd0, 1'b1, 0, 0, -1, 0, 0, '0, 1'b0);

      // Randomized mix including overlong bursts whose tail beats are dropped.
      for (int n = 0; n < 12; n++) begin
         logic        ln;
         int          lastb;
         ln = 1'($urandom_range(1, 0));
         if (ln) lastb = ($urandom_range(3, 0) == 0) ? int'($urandom_range(LB + 1, 0)) : LB - 1;
         else    lastb = ($urandom_range(3, 0) == 0) ? 1 : 0;
         run_txn(PADDR'({$urandom(), $urandom()}), 2'($urandom_range(3, 0)), ln,
                 int'($urandom_range(3, 0)), int'($urandom_range(2, 0)),
                 ($urandom_range(2, 0) == 0) ? int'($urandom_range(LB - 1, 0)) : -1,
                 lastb, 0, '0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
